// File: rtl/sprite_line_scheduler_pkg.sv
// rtl/sprite_line_scheduler_pkg.sv - shared constants for the sprite line scheduler
package sprite_line_scheduler_pkg;

  localparam int DEFAULT_SPRITE_SIZE = 16;

  localparam logic [3:0] CHAR_PACMAN = 4'd0;
  localparam logic [3:0] CHAR_BLINKY = 4'd1;
  localparam logic [3:0] CHAR_PINKY  = 4'd2;
  localparam logic [3:0] CHAR_INKY   = 4'd3;
  localparam logic [3:0] CHAR_CLYDE  = 4'd4;

  localparam logic [1:0] MEM_SEL_IDLE = 2'b00;
  localparam logic [1:0] MEM_SEL_TILE = 2'b01;
  localparam logic [1:0] MEM_SEL_CHAR = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EVAL   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

endpackage

// File: rtl/sprite_hit_priority.sv
// rtl/sprite_hit_priority.sv - combinational lowest-index sprite cover lookup
module sprite_hit_priority #(
  parameter int NUM_CHARS   = 5,
  parameter int COORD_W     = 10,
  parameter int SPRITE_SIZE = 16,
  parameter int ROW_W       = $clog2(SPRITE_SIZE)
) (
  input  logic [NUM_CHARS-1:0]         mask,
  input  logic [NUM_CHARS*COORD_W-1:0] char_x,
  input  logic [COORD_W-1:0]           pixel_x,
  output logic                         hit,
  output logic [3:0]                   winner,
  output logic [ROW_W-1:0]             dx
);

  logic [COORD_W-1:0] d;

  // Scan from the highest index down so the lowest covering char is the last write.
  always_comb begin
    hit    = 1'b0;
    winner = '0;
    dx     = '0;
    d      = '0;
    for (int k = NUM_CHARS - 1; k >= 0; k--) begin
      d = pixel_x - char_x[k*COORD_W +: COORD_W];
      if (mask[k] && (d < COORD_W'(SPRITE_SIZE))) begin
        hit    = 1'b1;
        winner = 4'(k);
        dx     = d[ROW_W-1:0];
      end
    end
  end

endmodule

// File: rtl/sprite_line_scheduler.sv
// rtl/sprite_line_scheduler.sv - hblank sprite evaluation and per-pixel memory source select
module sprite_line_scheduler
  import sprite_line_scheduler_pkg::*;
#(
  parameter int NUM_CHARS   = 5,
  parameter int SPRITE_SIZE = DEFAULT_SPRITE_SIZE,
  parameter int COORD_W     = 10
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_hblank_start,
  input  logic [COORD_W-1:0]           i_next_line_y,
  input  logic [NUM_CHARS*COORD_W-1:0] i_char_x,
  input  logic [NUM_CHARS*COORD_W-1:0] i_char_y,
  input  logic [NUM_CHARS-1:0]         i_char_enable,
  input  logic                         i_pixel_valid,
  input  logic [COORD_W-1:0]           i_pixel_x,
  output logic                         o_pixel_valid,
  output logic [1:0]                   o_mem_select,
  output logic [3:0]                   o_which_char,
  output logic [7:0]                   o_char_offset,
  output logic [5:0]                   o_tile_offset,
  output logic                         o_eval_busy,
  output logic [NUM_CHARS-1:0]         o_line_mask
);

  localparam int ROW_W = $clog2(SPRITE_SIZE);
  localparam int IDX_W = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;

  logic [1:0]                   state;
  logic [COORD_W-1:0]           eval_y;
  logic [IDX_W-1:0]             idx;
  logic [NUM_CHARS-1:0]         shadow_mask;
  logic [NUM_CHARS*ROW_W-1:0]   shadow_row;
  logic [NUM_CHARS*COORD_W-1:0] shadow_x;
  logic [NUM_CHARS-1:0]         active_mask;
  logic [NUM_CHARS*ROW_W-1:0]   active_row;
  logic [NUM_CHARS*COORD_W-1:0] active_x;
  logic [2:0]                   line_y_lo;

  logic [COORD_W-1:0] eval_char_y;
  logic [COORD_W-1:0] dy;
  logic               eval_hit;

  assign eval_char_y = i_char_y[idx*COORD_W +: COORD_W];
  assign dy          = eval_y - eval_char_y;
  assign eval_hit    = i_char_enable[idx] && (dy < COORD_W'(SPRITE_SIZE));

  // A new hblank always wins: it restarts evaluation from any state and drops the pending shadow.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      eval_y      <= '0;
      idx         <= '0;
      shadow_mask <= '0;
      shadow_row  <= '0;
      shadow_x    <= '0;
      active_mask <= '0;
      active_row  <= '0;
      active_x    <= '0;
      line_y_lo   <= '0;
    end else if (i_hblank_start) begin
      state       <= ST_EVAL;
      eval_y      <= i_next_line_y;
      idx         <= '0;
      shadow_mask <= '0;
    end else begin
      case (state)
        ST_EVAL: begin
          if (eval_hit) begin
            shadow_mask[idx]                 <= 1'b1;
            shadow_row[idx*ROW_W +: ROW_W]   <= dy[ROW_W-1:0];
            shadow_x[idx*COORD_W +: COORD_W] <= i_char_x[idx*COORD_W +: COORD_W];
          end
          if (idx == IDX_W'(NUM_CHARS - 1)) begin
            state <= ST_COMMIT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_COMMIT: begin
          active_mask <= shadow_mask;
          active_row  <= shadow_row;
          active_x    <= shadow_x;
          line_y_lo   <= eval_y[2:0];
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_eval_busy = (state == ST_EVAL);
  assign o_line_mask = active_mask;

  logic             pix_hit;
  logic [3:0]       pix_winner;
  logic [ROW_W-1:0] pix_dx;

  sprite_hit_priority #(
    .NUM_CHARS  (NUM_CHARS),
    .COORD_W    (COORD_W),
    .SPRITE_SIZE(SPRITE_SIZE),
    .ROW_W      (ROW_W)
  ) u_hit (
    .mask   (active_mask),
    .char_x (active_x),
    .pixel_x(i_pixel_x),
    .hit    (pix_hit),
    .winner (pix_winner),
    .dx     (pix_dx)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_pixel_valid <= 1'b0;
      o_mem_select  <= MEM_SEL_IDLE;
      o_which_char  <= '0;
      o_char_offset <= '0;
      o_tile_offset <= '0;
    end else begin
      o_pixel_valid <= i_pixel_valid;
      if (!i_pixel_valid) begin
        o_mem_select  <= MEM_SEL_IDLE;
        o_which_char  <= '0;
        o_char_offset <= '0;
        o_tile_offset <= '0;
      end else begin
        o_tile_offset <= {line_y_lo, i_pixel_x[2:0]};
        if (pix_hit) begin
          o_mem_select  <= MEM_SEL_CHAR;
          o_which_char  <= pix_winner;
          o_char_offset <= 8'({active_row[pix_winner*ROW_W +: ROW_W], pix_dx});
        end else begin
          o_mem_select  <= MEM_SEL_TILE;
          o_which_char  <= '0;
          o_char_offset <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// tb/tb_sprite_line_scheduler.sv - directed scoreboard bench for sprite_line_scheduler
module tb_sprite_line_scheduler;
  import sprite_line_scheduler_pkg::*;

  localparam int NC = 5;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          hblank_start;
  logic [CW-1:0] next_line_y;
  logic [NC*CW-1:0] char_x;
  logic [NC*CW-1:0] char_y;
  logic [NC-1:0] char_enable;
  logic          pixel_valid;
  logic [CW-1:0] pixel_x;
  logic          out_pixel_valid;
  logic [1:0]    mem_select;
  logic [3:0]    which_char;
  logic [7:0]    char_offset;
  logic [5:0]    tile_offset;
  logic          eval_busy;
  logic [NC-1:0] line_mask;

  always #5 clk = ~clk;

  sprite_line_scheduler #(.NUM_CHARS(NC), .SPRITE_SIZE(16), .COORD_W(CW)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_hblank_start(hblank_start),
    .i_next_line_y (next_line_y),
    .i_char_x      (char_x),
    .i_char_y      (char_y),
    .i_char_enable (char_enable),
    .i_pixel_valid (pixel_valid),
    .i_pixel_x     (pixel_x),
    .o_pixel_valid (out_pixel_valid),
    .o_mem_select  (mem_select),
    .o_which_char  (which_char),
    .o_char_offset (char_offset),
    .o_tile_offset (tile_offset),
    .o_eval_busy   (eval_busy),
    .o_line_mask   (line_mask)
  );

  typedef struct {
    logic       pv;
    logic [1:0] sel;
    logic [3:0] wc;
    logic [7:0] co;
    logic [5:0] to;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    hblank_start = 1'b0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("pixel_valid", {31'd0, out_pixel_valid}, {31'd0, e.pv});
      chk("mem_select", {30'd0, mem_select}, {30'd0, e.sel});
      chk("which_char", {28'd0, which_char}, {28'd0, e.wc});
      chk("char_offset", {24'd0, char_offset}, {24'd0, e.co});
      chk("tile_offset", {26'd0, tile_offset}, {26'd0, e.to});
    end
    pixel_valid = 1'b0;
  endtask

  task automatic pix(input logic v, input logic [CW-1:0] x, input logic [1:0] s,
                     input logic [3:0] w, input logic [7:0] co, input logic [5:0] to);
    exp_t e;
    pixel_valid = v;
    pixel_x     = x;
    e.pv = v; e.sel = s; e.wc = w; e.co = co; e.to = to;
    sb.push_back(e);
  endtask

  task automatic set_char(input int k, input logic [CW-1:0] x, input logic [CW-1:0] y,
                          input logic en);
    char_x[k*CW +: CW] = x;
    char_y[k*CW +: CW] = y;
    char_enable[k]     = en;
  endtask

  task automatic run_eval(input logic [CW-1:0] y, input logic [NC-1:0] new_mask,
                          input logic [NC-1:0] old_mask);
    hblank_start = 1'b1;
    next_line_y  = y;
    tick();
    for (int i = 0; i < NC; i++) begin
      chk("eval_busy", {31'd0, eval_busy}, 32'd1);
      tick();
    end
    chk("busy_in_commit", {31'd0, eval_busy}, 32'd0);
    chk("mask_before_commit", {27'd0, line_mask}, {27'd0, old_mask});
    tick();
    chk("mask_after_commit", {27'd0, line_mask}, {27'd0, new_mask});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pv"}, {31'd0, out_pixel_valid}, 32'd0);
    chk({tag, "_sel"}, {30'd0, mem_select}, 32'd0);
    chk({tag, "_wc"}, {28'd0, which_char}, 32'd0);
    chk({tag, "_co"}, {24'd0, char_offset}, 32'd0);
    chk({tag, "_to"}, {26'd0, tile_offset}, 32'd0);
    chk({tag, "_busy"}, {31'd0, eval_busy}, 32'd0);
    chk({tag, "_mask"}, {27'd0, line_mask}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; hblank_start = 1'b0; next_line_y = '0;
    char_x = '0; char_y = '0; char_enable = '0;
    pixel_valid = 1'b0; pixel_x = '0;
    #2;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // blinky at (100,50), line 57 -> row 7
    set_char(1, 10'd100, 10'd50, 1'b1);
    run_eval(10'd57, 5'b00010, 5'b00000);
    pix(1'b1, 10'd103, MEM_SEL_CHAR, CHAR_BLINKY, 8'd115, 6'd15); tick();
    pix(1'b1, 10'd116, MEM_SEL_TILE, 4'd0, 8'd0, 6'd12); tick();

    // reset at EVAL cycle 3 with a char pixel just registered
    hblank_start = 1'b1; next_line_y = 10'd57; tick();
    tick();
    pix(1'b1, 10'd103, MEM_SEL_CHAR, CHAR_BLINKY, 8'd115, 6'd15); tick();
    rst = 1'b1;
    #1;
    chk_all_zero("mid_eval_reset");
    #2;
    rst = 1'b0;
    tick();
    chk("idle_after_reset", {31'd0, eval_busy}, 32'd0);
    run_eval(10'd57, 5'b00010, 5'b00000);
    pix(1'b1, 10'd103, MEM_SEL_CHAR, CHAR_BLINKY, 8'd115, 6'd15); tick();

    // priority: pacman and inky overlap
    set_char(1, 10'd100, 10'd50, 1'b0);
    set_char(0, 10'd200, 10'd10, 1'b1);
    set_char(3, 10'd200, 10'd10, 1'b1);
    run_eval(10'd10, 5'b01001, 5'b00010);
    pix(1'b1, 10'd205, MEM_SEL_CHAR, CHAR_PACMAN, 8'd5, 6'd21); tick();
    set_char(0, 10'd200, 10'd10, 1'b0);
    run_eval(10'd10, 5'b01000, 5'b01001);
    pix(1'b1, 10'd205, MEM_SEL_CHAR, CHAR_INKY, 8'd5, 6'd21); tick();

    // horizontal wrap: pinky at x=1020
    set_char(3, 10'd200, 10'd10, 1'b0);
    set_char(2, 10'd1020, 10'd0, 1'b1);
    run_eval(10'd0, 5'b00100, 5'b01000);
    pix(1'b1, 10'd2,    MEM_SEL_CHAR, CHAR_PINKY, 8'd6, 6'd2); tick();
    pix(1'b1, 10'd1019, MEM_SEL_TILE, 4'd0, 8'd0, 6'd3); tick();
    pix(1'b1, 10'd1023, MEM_SEL_CHAR, CHAR_PINKY, 8'd3, 6'd7); tick();
    pix(1'b1, 10'd11,   MEM_SEL_CHAR, CHAR_PINKY, 8'd15, 6'd3); tick();
    pix(1'b1, 10'd12,   MEM_SEL_TILE, 4'd0, 8'd0, 6'd4); tick();

    // restart: second hblank at EVAL cycle 2, pixels keep the old table
    set_char(2, 10'd1020, 10'd0, 1'b0);
    set_char(4, 10'd300, 10'd25, 1'b1);
    hblank_start = 1'b1; next_line_y = 10'd200; tick();
    chk("restart_busy0", {31'd0, eval_busy}, 32'd1);
    tick();
    chk("restart_busy1", {31'd0, eval_busy}, 32'd1);
    hblank_start = 1'b1; next_line_y = 10'd30;
    pix(1'b1, 10'd2, MEM_SEL_CHAR, CHAR_PINKY, 8'd6, 6'd2); tick();
    for (int i = 0; i < NC; i++) begin
      chk("restart_busy", {31'd0, eval_busy}, 32'd1);
      chk("restart_old_mask", {27'd0, line_mask}, 32'd4);
      pix(1'b1, 10'd1023, MEM_SEL_CHAR, CHAR_PINKY, 8'd3, 6'd7); tick();
    end
    chk("restart_commit_busy", {31'd0, eval_busy}, 32'd0);
    chk("restart_commit_mask", {27'd0, line_mask}, 32'd4);
    tick();
    chk("restart_final_mask", {27'd0, line_mask}, 32'd16);
    pix(1'b1, 10'd310, MEM_SEL_CHAR, CHAR_CLYDE, 8'd90, 6'd54); tick();

    // invalid pixel with sprites present
    pix(1'b0, 10'd310, MEM_SEL_IDLE, 4'd0, 8'd0, 6'd0); tick();

    // vertical boundary: dy = 15 hits, dy = 16 misses
    run_eval(10'd40, 5'b10000, 5'b10000);
    pix(1'b1, 10'd300, MEM_SEL_CHAR, CHAR_CLYDE, 8'd240, 6'd4); tick();
    run_eval(10'd41, 5'b00000, 5'b10000);
    pix(1'b1, 10'd300, MEM_SEL_TILE, 4'd0, 8'd0, 6'd12); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
